// File: rtl/litedram_port_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone LiteDRAM user port among
// NUM_M pipelined Wishbone masters, with one transaction outstanding at a time.
module litedram_port_arbiter #(
    parameter int NUM_M   = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023,
    localparam int SEL_W  = DATA_W / 8,
    localparam int IDX_W  = $clog2(NUM_M)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_M-1:0]        m_cyc,
    input  logic [NUM_M-1:0]        m_stb,
    input  logic [NUM_M-1:0]        m_we,
    input  logic [NUM_M*ADDR_W-1:0] m_adr,
    input  logic [NUM_M*DATA_W-1:0] m_dat_w,
    input  logic [NUM_M*SEL_W-1:0]  m_sel,
    output logic [NUM_M-1:0]        m_stall,
    output logic [NUM_M-1:0]        m_ack,
    output logic [NUM_M-1:0]        m_err,
    output logic [DATA_W-1:0]       m_dat_r,
    output logic                    s_cyc,
    output logic                    s_stb,
    output logic                    s_we,
    output logic [ADDR_W-1:0]       s_adr,
    output logic [DATA_W-1:0]       s_dat_w,
    output logic [SEL_W-1:0]        s_sel,
    input  logic                    s_stall,
    input  logic                    s_ack,
    input  logic                    s_err,
    input  logic [DATA_W-1:0]       s_dat_r,
    output logic [IDX_W-1:0]        grant_idx,
    output logic                    busy
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [NUM_M-1:0] req;
    logic             any_req;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] rr_last;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             resp;
    logic             cyc_lost;
    logic             grant_load;
    logic             fwd_ack;
    logic             fwd_err;

    // First requester after the most recent grant, wrapping modulo NUM_M.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_M-1:0] r,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] w;
        logic             found;
        w     = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_M; k++) begin
            for (int i = 0; i < NUM_M; i++) begin
                if (!found && r[i] && (i == (int'(last) + k) % NUM_M)) begin
                    found = 1'b1;
                    w     = IDX_W'(i);
                end
            end
        end
        return w;
    endfunction

    assign req      = m_cyc & m_stb;
    assign any_req  = |req;
    assign winner   = rr_pick(req, rr_last);
    assign cyc_lost = !m_cyc[grant_idx];
    assign resp     = s_ack | s_err;
    assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT - 1));

    assign s_cyc = (state != IDLE);
    assign s_stb = (state == ISSUE);
    assign busy  = (state != IDLE);

    // Only the current winner sees its strobe taken, and only while idle.
    always_comb begin
        m_stall = '1;
        if (rst_n && (state == IDLE) && any_req) begin
            m_stall[winner] = 1'b0;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_load = 1'b0;
        fwd_ack    = 1'b0;
        fwd_err    = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_load = 1'b1;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                if (cyc_lost) begin
                    // An accepted strobe still owes a response that must be swallowed.
                    state_nxt = (!s_stall && !resp) ? DRAIN : IDLE;
                end else if (!s_stall && resp) begin
                    fwd_err   = s_err;
                    fwd_ack   = !s_err;
                    state_nxt = IDLE;
                end else if (tmo_hit) begin
                    fwd_err   = 1'b1;
                    state_nxt = IDLE;
                end else if (!s_stall) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cyc_lost) begin
                    state_nxt = resp ? IDLE : DRAIN;
                end else if (resp) begin
                    fwd_err   = s_err;
                    fwd_ack   = !s_err;
                    state_nxt = IDLE;
                end else if (tmo_hit) begin
                    fwd_err   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (resp || tmo_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_idx <= '0;
            rr_last   <= IDX_W'(NUM_M - 1);
            m_ack     <= '0;
            m_err     <= '0;
            m_dat_r   <= '0;
            tmo_cnt   <= '0;
        end else begin
            state <= state_nxt;
            m_ack <= '0;
            m_err <= '0;
            if (grant_load) begin
                grant_idx <= winner;
                rr_last   <= winner;
            end
            if (fwd_ack) begin
                m_ack[grant_idx] <= 1'b1;
                m_dat_r          <= s_dat_r;
            end
            if (fwd_err) begin
                m_err[grant_idx] <= 1'b1;
            end
            if (grant_load) begin
                tmo_cnt <= '0;
            end else if (state != IDLE) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end

    // Request payload is captured at grant and held for the whole transaction.
    always_ff @(posedge clk) begin
        if (grant_load) begin
            s_we    <= m_we[winner];
            s_adr   <= m_adr[int'(winner) * ADDR_W +: ADDR_W];
            s_dat_w <= m_dat_w[int'(winner) * DATA_W +: DATA_W];
            s_sel   <= m_sel[int'(winner) * SEL_W +: SEL_W];
        end
    end

endmodule
